// File: rtl/sweep_pkg.sv
// Shared definitions for the exhaustive vector sweep controller:
// FSM state encoding and the MISR polynomial/seed.
package sweep_pkg;

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        WAIT,
        CAPTURE,
        EMIT,
        FIN
    } sweep_state_t;

    localparam logic [15:0] MISR_POLY = 16'h1021;
    localparam logic [15:0] MISR_SEED = 16'hFFFF;

endpackage

// File: rtl/sweep_misr16.sv
// 16-bit multiple-input signature register that compacts every accepted
// record into a single signature word.
module sweep_misr16
    import sweep_pkg::*;
(
    input  logic        CK,
    input  logic        reset,
    input  logic        seed_load,
    input  logic        en,
    input  logic [15:0] din,
    output logic [15:0] sig
);

    // Seeding wins over a same-cycle update so each sweep starts from a known word.
    always_ff @(posedge CK) begin
        if (reset) begin
            sig <= 16'h0000;
        end else if (seed_load) begin
            sig <= MISR_SEED;
        end else if (en) begin
            sig <= {sig[14:0], 1'b0} ^ (sig[15] ? MISR_POLY : 16'h0000) ^ din;
        end
    end

endmodule

// File: rtl/vector_sweep_ctrl.sv
// Walks every input vector through an external DUT, waits for it to settle,
// captures the response and offers a {vector, response} record to a logger.
module vector_sweep_ctrl
    import sweep_pkg::*;
#(
    parameter int N_IN   = 3,
    parameter int OUT_W  = 1,
    parameter int SETTLE = 1
) (
    input  logic              CK,
    input  logic              reset,
    input  logic              start,
    output logic [N_IN-1:0]   dut_in,
    input  logic [OUT_W-1:0]  dut_out,
    output logic              rec_valid,
    input  logic              rec_ready,
    output logic [N_IN-1:0]   rec_vec,
    output logic [OUT_W-1:0]  rec_resp,
    output logic              busy,
    output logic              done,
    output logic [15:0]       signature
);

    if (N_IN + OUT_W > 16 || N_IN < 1 || N_IN > 16 || OUT_W < 1 || OUT_W > 8
        || SETTLE < 1 || SETTLE > 15) begin : g_param_check
        $error("vector_sweep_ctrl: illegal N_IN/OUT_W/SETTLE combination");
    end

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    sweep_state_t    state, state_nxt;
    logic [N_IN-1:0] counter;
    logic [3:0]      settle_cnt;
    logic            handshake;
    logic            last_vec;
    logic [15:0]     misr_din;

    assign handshake = (state == EMIT) && rec_ready;
    assign last_vec  = &counter;

    always_ff @(posedge CK) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        done      = 1'b0;
        rec_valid = 1'b0;
        dut_in    = counter;
        case (state)
            IDLE: begin
                busy   = 1'b0;
                dut_in = '0;
                if (start) begin
                    state_nxt = APPLY;
                end
            end
            APPLY: state_nxt = WAIT;
            WAIT: begin
                if (settle_cnt == SETTLE_LAST) begin
                    state_nxt = CAPTURE;
                end
            end
            CAPTURE: state_nxt = EMIT;
            EMIT: begin
                rec_valid = 1'b1;
                if (rec_ready) begin
                    state_nxt = last_vec ? FIN : APPLY;
                end
            end
            FIN: begin
                done      = 1'b1;
                dut_in    = '0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The counter stops on the all-ones vector instead of wrapping, so FIN sees it intact.
    always_ff @(posedge CK) begin
        if (reset) begin
            counter    <= '0;
            settle_cnt <= '0;
            rec_vec    <= '0;
            rec_resp   <= '0;
        end else begin
            if (state == IDLE && start) begin
                counter <= '0;
            end else if (handshake && !last_vec) begin
                counter <= counter + N_IN'(1);
            end
            if (state == WAIT) begin
                settle_cnt <= settle_cnt + 4'd1;
            end else begin
                settle_cnt <= '0;
            end
            if (state == CAPTURE) begin
                rec_vec  <= counter;
                rec_resp <= dut_out;
            end
        end
    end

    always_comb begin
        misr_din = '0;
        misr_din[N_IN+OUT_W-1:0] = {rec_vec, rec_resp};
    end

    sweep_misr16 u_misr (
        .CK        (CK),
        .reset     (reset),
        .seed_load (state == IDLE && start),
        .en        (handshake),
        .din       (misr_din),
        .sig       (signature)
    );

endmodule

// File: tb/tb_vector_sweep_ctrl.sv
// Randomized self-checking bench for vector_sweep_ctrl, compared against a
// record-level model of the sweep (vector order, responses, timing, signature).
module tb_vector_sweep_ctrl;

    localparam int LIMIT = 500;

    logic        CK;
    logic        reset;
    logic        start;
    logic [2:0]  dut_in;
    logic        dut_out;
    logic        rec_valid;
    logic        rec_ready;
    logic [2:0]  rec_vec;
    logic        rec_resp;
    logic        busy;
    logic        done;
    logic [15:0] signature;

    logic        start_4;
    logic [2:0]  dut_in_4;
    logic        drv_4;
    logic        rec_valid_4;
    logic        rec_ready_4;
    logic [2:0]  rec_vec_4;
    logic        rec_resp_4;
    logic        busy_4;
    logic        done_4;
    logic [15:0] signature_4;

    logic        resp_tbl [8];
    int          got_vec[$];
    int          got_resp[$];
    int          err_count = 0;
    int          check_count = 0;

    logic        prev_stall = 1'b0;
    logic [2:0]  prev_vec = '0;
    logic        prev_resp = 1'b0;

    assign dut_out = resp_tbl[dut_in];

    vector_sweep_ctrl #(.N_IN(3), .OUT_W(1), .SETTLE(1)) u_dut (
        .CK        (CK),
        .reset     (reset),
        .start     (start),
        .dut_in    (dut_in),
        .dut_out   (dut_out),
        .rec_valid (rec_valid),
        .rec_ready (rec_ready),
        .rec_vec   (rec_vec),
        .rec_resp  (rec_resp),
        .busy      (busy),
        .done      (done),
        .signature (signature)
    );

    vector_sweep_ctrl #(.N_IN(3), .OUT_W(1), .SETTLE(4)) u_dut4 (
        .CK        (CK),
        .reset     (reset),
        .start     (start_4),
        .dut_in    (dut_in_4),
        .dut_out   (drv_4),
        .rec_valid (rec_valid_4),
        .rec_ready (rec_ready_4),
        .rec_vec   (rec_vec_4),
        .rec_resp  (rec_resp_4),
        .busy      (busy_4),
        .done      (done_4),
        .signature (signature_4)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        if (got !== exp) begin
            err_count++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Signature of a full sweep: seed, then fold each {vec, resp} word in vector order.
    function automatic logic [15:0] model_sig(input logic r [8]);
        logic [15:0] s;
        logic [15:0] word;
        s = 16'hFFFF;
        for (int v = 0; v < 8; v++) begin
            word = 16'(v * 2 + int'(r[v]));
            s = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ word;
        end
        return s;
    endfunction

    // Logger side: collect accepted records and make sure stalled records hold still.
    always @(negedge CK) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checkOutput("stall_valid", 32'(rec_valid), 32'd1);
                checkOutput("stall_vec", 32'(rec_vec), 32'(prev_vec));
                checkOutput("stall_resp", 32'(rec_resp), 32'(prev_resp));
                checkOutput("stall_dut_in", 32'(dut_in), 32'(prev_vec));
            end
            if (rec_valid && rec_ready) begin
                got_vec.push_back(int'(rec_vec));
                got_resp.push_back(int'(rec_resp));
            end
            prev_stall = rec_valid && !rec_ready;
            prev_vec   = rec_vec;
            prev_resp  = rec_resp;
        end
    end

    // Runs one sweep from a start pulse until done; cycles counts edges from APPLY to FIN.
    task automatic applyStimulus(input int stall_vec, input int stall_len, input bit rnd,
                                 output int cycles, output int stalls);
        int stall_left;
        stall_left = stall_len;
        stalls = 0;
        got_vec.delete();
        got_resp.delete();
        start = 1'b1;
        @(posedge CK); #1;
        start = 1'b0;
        cycles = 0;
        while (!done && cycles < LIMIT) begin
            if (rnd) begin
                rec_ready = ($urandom_range(0, 3) != 0);
                start     = ($urandom_range(0, 7) == 0);
            end else if (rec_valid && int'(rec_vec) == stall_vec && stall_left > 0) begin
                rec_ready = 1'b0;
                stall_left--;
            end else begin
                rec_ready = 1'b1;
            end
            if (rec_valid && !rec_ready) stalls++;
            @(posedge CK); #1;
            cycles++;
        end
        start = 1'b0;
        rec_ready = 1'b1;
        if (!done) checkOutput("sweep_timeout", 32'(cycles), 32'(LIMIT + 1));
    endtask

    // Called in the FIN cycle: checks the records, then pokes start in FIN.
    task automatic checkSweep(input int cycles, input int exp_cycles);
        checkOutput("sweep_cycles", 32'(cycles), 32'(exp_cycles));
        checkOutput("rec_count", 32'(got_vec.size()), 32'd8);
        for (int i = 0; i < 8 && i < got_vec.size(); i++) begin
            checkOutput("rec_vec_order", 32'(got_vec[i]), 32'(i));
            checkOutput("rec_resp_val", 32'(got_resp[i]), 32'(resp_tbl[i]));
        end
        checkOutput("signature", 32'(signature), 32'(model_sig(resp_tbl)));
        checkOutput("fin_dut_in", 32'(dut_in), 32'd0);
        start = 1'b1;
        @(posedge CK); #1;
        start = 1'b0;
        checkOutput("done_one_cycle", 32'(done), 32'd0);
        checkOutput("idle_after_fin", 32'(busy), 32'd0);
        @(posedge CK); #1;
        checkOutput("no_restart_from_fin", 32'(busy), 32'd0);
        checkOutput("signature_hold", 32'(signature), 32'(model_sig(resp_tbl)));
        checkOutput("rec_count_hold", 32'(got_vec.size()), 32'd8);
    endtask

    initial begin
        int cycles;
        int stalls;
        int n;
        logic r4 [8];

        reset = 1'b1;
        start = 1'b0;
        rec_ready = 1'b1;
        start_4 = 1'b0;
        rec_ready_4 = 1'b1;
        drv_4 = 1'b0;
        foreach (resp_tbl[i]) resp_tbl[i] = 1'b0;
        repeat (3) @(posedge CK);
        #1;
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_valid", 32'(rec_valid), 32'd0);
        checkOutput("reset_dut_in", 32'(dut_in), 32'd0);
        checkOutput("reset_rec_vec", 32'(rec_vec), 32'd0);
        checkOutput("reset_rec_resp", 32'(rec_resp), 32'd0);
        checkOutput("reset_signature", 32'(signature), 32'd0);
        checkOutput("reset_signature_4", 32'(signature_4), 32'd0);
        reset = 1'b0;
        @(posedge CK); #1;

        $display("[TB] AND-gate sweep");
        foreach (resp_tbl[i]) resp_tbl[i] = (i == 7);
        applyStimulus(-1, 0, 1'b0, cycles, stalls);
        checkSweep(cycles, 32);

        $display("[TB] logger stall on vector 011");
        foreach (resp_tbl[i]) resp_tbl[i] = 1'($urandom);
        applyStimulus(3, 5, 1'b0, cycles, stalls);
        checkSweep(cycles, 37);

        $display("[TB] random ready and stray start pulses");
        repeat (3) begin
            foreach (resp_tbl[i]) resp_tbl[i] = 1'($urandom);
            applyStimulus(-1, 0, 1'b1, cycles, stalls);
            checkSweep(cycles, 32 + stalls);
        end

        $display("[TB] reset during WAIT of vector 100");
        foreach (resp_tbl[i]) resp_tbl[i] = 1'($urandom);
        got_vec.delete();
        got_resp.delete();
        start = 1'b1;
        @(posedge CK); #1;
        start = 1'b0;
        n = 0;
        while (dut_in != 3'b100 && n < LIMIT) begin
            @(posedge CK); #1;
            n++;
        end
        @(posedge CK); #1;
        checkOutput("pre_reset_count", 32'(got_vec.size()), 32'd4);
        checkOutput("pre_reset_wait_valid", 32'(rec_valid), 32'd0);
        reset = 1'b1;
        @(posedge CK); #1;
        reset = 1'b0;
        checkOutput("mid_reset_busy", 32'(busy), 32'd0);
        checkOutput("mid_reset_signature", 32'(signature), 32'd0);
        checkOutput("mid_reset_dut_in", 32'(dut_in), 32'd0);
        checkOutput("mid_reset_valid", 32'(rec_valid), 32'd0);
        @(posedge CK); #1;
        checkOutput("post_reset_valid", 32'(rec_valid), 32'd0);
        checkOutput("post_reset_busy", 32'(busy), 32'd0);
        applyStimulus(-1, 0, 1'b0, cycles, stalls);
        checkSweep(cycles, 32);

        $display("[TB] SETTLE=4 capture timing");
        drv_4 = 1'b0;
        start_4 = 1'b1;
        @(posedge CK); #1;
        start_4 = 1'b0;
        n = 0;
        checkOutput("settle4_apply_vec", 32'(dut_in_4), 32'd0);
        repeat (3) begin
            @(posedge CK); #1;
            n++;
        end
        drv_4 = 1'b1;
        repeat (2) begin
            @(posedge CK); #1;
            n++;
        end
        checkOutput("settle4_not_yet_valid", 32'(rec_valid_4), 32'd0);
        @(posedge CK); #1;
        n++;
        checkOutput("settle4_valid_at_6", 32'(rec_valid_4), 32'd1);
        checkOutput("settle4_rec_vec", 32'(rec_vec_4), 32'd0);
        checkOutput("settle4_late_change_captured", 32'(rec_resp_4), 32'd1);
        drv_4 = 1'b0;
        while (!done_4 && n < LIMIT) begin
            @(posedge CK); #1;
            n++;
        end
        checkOutput("settle4_total_cycles", 32'(n), 32'd56);
        foreach (r4[i]) r4[i] = (i == 0);
        checkOutput("settle4_signature", 32'(signature_4), 32'(model_sig(r4)));
        @(posedge CK); #1;

        $display("Result: errors=%0d of %0d checks", err_count, check_count);
        $finish;
    end

endmodule

// File: doc/vector_sweep_ctrl.md
VECTOR_SWEEP_CTRL -- requirements
Module: vector_sweep_ctrl

Interface
REQ-001 SHALL have parameter N_IN, default 3: DUT input vector width; legal range 1..16.
REQ-002 SHALL have parameter OUT_W, default 1: DUT response width; legal range 1..8.
REQ-003 SHALL have parameter SETTLE, default 1: cycles waited after applying a vector before capture; legal range 1..15.
REQ-004 SHALL have port CK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-006 SHALL have port start, input, 1 bit: begins an exhaustive sweep when sampled high in IDLE.
REQ-007 SHALL have port dut_in, output, N_IN bits: stimulus vector driven to the DUT.
REQ-008 SHALL have port dut_out, input, OUT_W bits: DUT response.
REQ-009 SHALL have port rec_valid, output, 1 bit: a record is offered to the logger.
REQ-010 SHALL have port rec_ready, input, 1 bit: the logger accepts the record.
REQ-011 SHALL have port rec_vec, output, N_IN bits: vector of the offered record.
REQ-012 SHALL have port rec_resp, output, OUT_W bits: captured response of the offered record.
REQ-013 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse at sweep completion.
REQ-015 SHALL have port signature, output, 16 bits: MISR compaction of all accepted records.

Function
REQ-016 SHALL implement FSM states IDLE, APPLY, WAIT, CAPTURE, EMIT, FIN.
REQ-017 SHALL transition IDLE->APPLY on start=1, clearing the vector counter to 0 and seeding signature to 16'hFFFF.
REQ-018 SHALL drive dut_in = counter from APPLY through EMIT, holding it stable, and SHALL drive dut_in = 0 in IDLE and FIN.
REQ-019 SHALL transition APPLY->WAIT after 1 cycle, then stay in WAIT exactly SETTLE cycles before moving to CAPTURE.
REQ-020 SHALL register dut_out into rec_resp in CAPTURE, then move to EMIT.
REQ-021 SHALL assert rec_valid only in EMIT, holding rec_vec/rec_resp stable until rec_valid && rec_ready.
REQ-022 SHALL, on handshake: update signature; if counter = 2^N_IN-1 go to FIN, else increment counter and go to APPLY.
REQ-023 SHALL give a per-vector latency of SETTLE+3 cycles with rec_ready held high; each cycle of rec_ready low adds one cycle.
REQ-024 SHALL never wrap the counter: the all-ones vector is the last vector issued, and the sweep issues exactly 2^N_IN records.
REQ-025 SHALL pulse done for exactly one cycle in FIN, then return to IDLE; signature SHALL hold its value until the next start.
REQ-026 SHALL ignore start when not in IDLE, including start asserted in FIN.
REQ-027 SHALL update the MISR as: sig <= {sig[14:0],1'b0} ^ (sig[15] ? 16'h1021 : 0) ^ zero-extended {rec_vec, rec_resp}.
REQ-028 SHALL reject N_IN+OUT_W > 16 at elaboration.

Reset
REQ-029 SHALL, while reset=1, force state IDLE, counter 0, dut_in 0, rec_valid 0, rec_vec 0, rec_resp 0, busy 0, done 0, signature 16'h0000.
REQ-030 SHALL let reset win over every other event, including mid-sweep and during an EMIT stall; no record SHALL be emitted in the cycle after reset.

Structure
REQ-031 SHALL place the state enum, the MISR polynomial 16'h1021, and the MISR seed 16'hFFFF in shared package sweep_pkg.
REQ-032 SHALL implement the signature in sub-module sweep_misr16, with ports CK, reset, seed_load, en, din[15:0], and sig[15:0].

Verification
REQ-033 Bench SHALL cover: N_IN=3, SETTLE=1, rec_ready=1, start pulse -> 8 records with vec 000..111 in order, 32 cycles from APPLY to FIN, then one done pulse.
REQ-034 Bench SHALL cover: a DUT computing AND of its inputs -> rec_resp=1 only for vec 111; signature matches a reference-model MISR.
REQ-035 Bench SHALL cover: rec_ready low for 5 cycles on vec 011 -> rec_valid held, rec_vec=011 stable, dut_in unchanged, total time +5.
REQ-036 Bench SHALL cover: start re-asserted mid-sweep and in FIN -> no restart, and the record count stays 8.
REQ-037 Bench SHALL cover: reset asserted during WAIT of vec 100 -> next cycle IDLE, busy=0, signature=0; a new start sweeps from 000.
REQ-038 Bench SHALL cover: SETTLE=4 -> capture occurs 5 cycles after APPLY, and a response changing on settle-cycle 3 is captured.
